// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Decode-and-issue stage in front of the MIPS32 ALU.
//
// Each accepted instruction, together with its register-file operands, is
// decoded into an ALU operation code, two operands, a destination register
// and a write-back flag. The result goes into a 2-entry skid buffer and is
// presented to the execute stage in FIFO order. Illegal instructions are
// counted with a saturating 8-bit counter.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid && ready are both high. The sender holds valid and data
// stable until that edge. in_ready comes from registered state only, so it
// has no combinational path from out_ready.
//
// Ports:
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   flush            synchronous; drops every buffered entry and any input
//                    offered in the same cycle
//   in_valid/in_ready            upstream handshake
//   in_instr                     MIPS32 instruction word
//   in_rs_data, in_rt_data       register values for instr[25:21], [20:16]
//   out_valid/out_ready          downstream handshake
//   out_a, out_b                 ALU operands
//   out_alu_control              4-bit ALU operation code
//   out_dest                     destination register
//   out_reg_write                result is written back
//   out_illegal                  entry was undecodable
//   illegal_count                saturating count of accepted illegal instrs
//   buf_state                    debug view of the buffer FSM
//                                (0 = EMPTY, 1 = ONE, 2 = TWO)
// ---------------------------------------------------------------------------
module alu_issue_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs_data,
  input  logic [31:0] in_rt_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [3:0]  out_alu_control,
  output logic [4:0]  out_dest,
  output logic        out_reg_write,
  output logic        out_illegal,
  output logic [7:0]  illegal_count,
  output logic [1:0]  buf_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  dest;
    logic        reg_write;
    logic        illegal;
  } entry_t;

  // ---------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt_field;
  logic [4:0]  rd_field;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        unused_rs_field;

  assign opcode   = in_instr[31:26];
  assign funct    = in_instr[5:0];
  assign rt_field = in_instr[20:16];
  assign rd_field = in_instr[15:11];
  assign imm_sext = {{16{in_instr[15]}}, in_instr[15:0]};
  assign imm_zext = {16'b0, in_instr[15:0]};
  // The rs register is already resolved into in_rs_data upstream.
  assign unused_rs_field = ^in_instr[25:21];

  // ---------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------
  entry_t      dec;
  logic        dec_legal;
  logic        dec_writes;
  logic [3:0]  dec_ctrl;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_dest;

  always_comb begin
    dec_legal  = 1'b1;
    dec_writes = 1'b0;
    dec_ctrl   = 4'b0010;
    dec_a      = in_rs_data;
    dec_b      = in_rt_data;
    dec_dest   = 5'd0;

    case (opcode)
      6'h00: begin
        dec_dest   = rd_field;
        dec_writes = 1'b1;
        case (funct)
          6'h24: dec_ctrl = 4'b0000;               // AND
          6'h25: dec_ctrl = 4'b0001;               // OR
          6'h20,
          6'h21: dec_ctrl = 4'b0010;               // ADD / ADDU
          6'h26: dec_ctrl = 4'b0100;               // XOR
          6'h18: dec_ctrl = 4'b0101;               // MULT
          6'h22,
          6'h23: dec_ctrl = 4'b0110;               // SUB / SUBU
          6'h2A: dec_ctrl = 4'b0111;               // SLT
          6'h1A: dec_ctrl = 4'b1011;               // DIV
          6'h27: dec_ctrl = 4'b1100;               // NOR
          // Shifts take the value from rt and pass the low half of the
          // instruction as b, which puts shamt in b[10:6] for the ALU.
          6'h00: begin
            dec_ctrl = 4'b1000;                    // SLL
            dec_a    = in_rt_data;
            dec_b    = imm_zext;
          end
          6'h02: begin
            dec_ctrl = 4'b1001;                    // SRL
            dec_a    = in_rt_data;
            dec_b    = imm_zext;
          end
          6'h03: begin
            dec_ctrl = 4'b1010;                    // SRA
            dec_a    = in_rt_data;
            dec_b    = imm_zext;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08,
      6'h09: begin                                  // ADDI / ADDIU
        dec_ctrl   = 4'b0010;
        dec_b      = imm_sext;
        dec_dest   = rt_field;
        dec_writes = 1'b1;
      end
      6'h0A: begin                                  // SLTI
        dec_ctrl   = 4'b0111;
        dec_b      = imm_sext;
        dec_dest   = rt_field;
        dec_writes = 1'b1;
      end
      6'h0C: begin                                  // ANDI
        dec_ctrl   = 4'b0000;
        dec_b      = imm_zext;
        dec_dest   = rt_field;
        dec_writes = 1'b1;
      end
      6'h0D: begin                                  // ORI
        dec_ctrl   = 4'b0001;
        dec_b      = imm_zext;
        dec_dest   = rt_field;
        dec_writes = 1'b1;
      end
      6'h0E: begin                                  // XORI
        dec_ctrl   = 4'b0100;
        dec_b      = imm_zext;
        dec_dest   = rt_field;
        dec_writes = 1'b1;
      end
      6'h23: begin                                  // LW: address = rs + offset
        dec_ctrl   = 4'b0010;
        dec_b      = imm_sext;
        dec_dest   = rt_field;
        dec_writes = 1'b1;
      end
      6'h2B: begin                                  // SW: address only, no write
        dec_ctrl   = 4'b0010;
        dec_b      = imm_sext;
        dec_dest   = rt_field;
        dec_writes = 1'b0;
      end
      6'h04: begin                                  // BEQ: compare by subtraction
        dec_ctrl   = 4'b0110;
        dec_writes = 1'b0;
      end
      default: dec_legal = 1'b0;
    endcase

    dec = '0;
    if (dec_legal) begin
      dec.a         = dec_a;
      dec.b         = dec_b;
      dec.ctrl      = dec_ctrl;
      dec.dest      = dec_dest;
      // Writes to $zero are dropped here so execute never has to check.
      dec.reg_write = dec_writes && (dec_dest != 5'd0);
      dec.illegal   = 1'b0;
    end else begin
      // Undecodable: harmless ADD of rs and rt that never writes back.
      dec.a         = in_rs_data;
      dec.b         = in_rt_data;
      dec.ctrl      = 4'b0010;
      dec.dest      = 5'd0;
      dec.reg_write = 1'b0;
      dec.illegal   = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Skid buffer FSM (state = occupancy), head feeds the outputs directly
  // ---------------------------------------------------------------------
  state_t state;
  entry_t head_q;
  entry_t tail_q;
  logic   out_valid_q;
  logic   in_ready_q;
  logic [7:0] count_q;

  logic accept;
  logic emit;

  // A flush cycle never stores its input, so it is not an acceptance.
  assign accept = in_valid && in_ready_q && !flush;
  assign emit   = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      count_q     <= 8'd0;
    end else begin
      if (accept && dec.illegal && (count_q != 8'hFF)) begin
        count_q <= count_q + 8'd1;
      end

      if (flush) begin
        state       <= EMPTY;
        head_q      <= '0;
        tail_q      <= '0;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              head_q      <= dec;
              state       <= ONE;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b1;
            end
          end
          ONE: begin
            if (accept && !emit) begin
              tail_q      <= dec;
              state       <= TWO;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else if (emit && !accept) begin
              state       <= EMPTY;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
            end else if (emit && accept) begin
              // Pass-through: new entry replaces the departing head.
              head_q <= dec;
            end
          end
          TWO: begin
            // in_ready is low here, so only an emit can change anything.
            if (emit) begin
              head_q      <= tail_q;
              state       <= ONE;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b1;
            end
          end
          default: begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign out_a           = head_q.a;
  assign out_b           = head_q.b;
  assign out_alu_control = head_q.ctrl;
  assign out_dest        = head_q.dest;
  assign out_reg_write   = head_q.reg_write;
  assign out_illegal     = head_q.illegal;
  assign illegal_count   = count_q;
  assign buf_state       = state;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-issue stage that sits in front of the MIPS32 ALU. It accepts fetched instructions plus register-file operands over a valid/ready handshake and decodes each one into the ALU's 4-bit operation code and operands. It buffers results in a 2-entry skid buffer and presents them to the execute stage over a second valid/ready handshake. It also counts illegal instructions.

## Interface
- No parameters; all widths are fixed by the 32-bit datapath.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; discards all buffered entries
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept an instruction this cycle
- in_instr  in  32  MIPS32 instruction word
- in_rs_data  in  32  register value selected by instr[25:21]
- in_rt_data  in  32  register value selected by instr[20:16]
- out_valid  out  1  head entry is valid
- out_ready  in  1  execute stage consumes the head entry
- out_a  out  32  ALU operand a
- out_b  out  32  ALU operand b
- out_alu_control  out  4  ALU operation code
- out_dest  out  5  destination register
- out_reg_write  out  1  result is written back
- out_illegal  out  1  entry was undecodable
- illegal_count  out  8  saturating count of accepted illegal instructions

## Operation
- Accept when in_valid && in_ready. Emit when out_valid && out_ready. Entries leave in FIFO order.
- R-type (opcode 0x00); a=rs, b=rt, dest=instr[15:11]:
  - AND 0x24→0000; OR 0x25→0001; ADD/ADDU 0x20/0x21→0010; XOR 0x26→0100
  - MULT 0x18→0101; SUB/SUBU 0x22/0x23→0110; SLT 0x2A→0111; DIV 0x1A→1011; NOR 0x27→1100
- Shifts (R-type): SLL 0x00→1000, SRL 0x02→1001, SRA 0x03→1010. For these, a=rt and b={16'b0,instr[15:0]}, so that shamt lands in b[10:6].
- I-type; a=rs, dest=instr[20:16]:
  - ADDI/ADDIU 0x08/0x09→0010, sign-extended immediate
  - SLTI 0x0A→0111, sign-extended immediate
  - ANDI 0x0C→0000, ORI 0x0D→0001, XORI 0x0E→0100, all zero-extended immediate
  - LW 0x23, SW 0x2B→0010, sign-extended offset
- BEQ 0x04→0110, a=rs, b=rt, no write.
- out_reg_write=1 only for R-type/I-type ALU ops and LW, and only when dest≠0. SW and BEQ force 0.
- Any other opcode/funct is illegal:
  - out_alu_control=0010, out_reg_write=0, out_dest=0, out_illegal=1, operands as R-type
  - illegal_count increments on acceptance, saturating at 255
- Buffer FSM, encoded by occupancy:
  - EMPTY: accept→ONE.
  - ONE: accept without emit→TWO; emit without accept→EMPTY; both or neither→ONE.
  - TWO: no accept is possible; emit→ONE.
- in_ready = (state≠TWO). It is a function of registered state only, with no combinational path from out_ready.
- flush: next state is EMPTY, all entries are dropped, and an input offered in the same cycle is not stored. illegal_count is unaffected by flush, and an illegal instruction offered in a flush cycle is not counted.

## Timing
- Reset values: state EMPTY, in_ready=1, out_valid=0, all out_* data=0, illegal_count=0.
- Latency: an instruction accepted at edge N is visible on out_* after edge N (out_valid=1 in cycle N+1).
- Throughput: 1 instruction/cycle while out_ready stays high. Occupancy never exceeds 2.
- out_* is stable while out_valid && !out_ready.
- The second entry shifts to the head in the same edge as the emit.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Test plan
- Reset, then ADD $3,$1,$2 with rs=5, rt=7, out_ready=1 → next cycle out_valid=1, control=0010, a=5, b=7, dest=3, reg_write=1.
- SRA $4,$5,8 with rt=0x80000000 → control=1010, a=0x80000000, b[10:6]=8. ADDI $t,$s,-1 → b=0xFFFFFFFF. ORI imm 0x8000 → b=0x00008000.
- Hold out_ready=0 and offer 3 instructions back-to-back → the first two are accepted, then in_ready=0. Raise out_ready → entries emit in order, and in_ready returns to 1 after the first emit.
- Opcode 0x3F offered 300 times → out_illegal=1, reg_write=0, illegal_count sticks at 255.
- Occupancy TWO, then flush together with in_valid=1 → next cycle out_valid=0, in_ready=1, and nothing is emitted. ADD with rd=0 → reg_write=0. SW, BEQ → reg_write=0.
- Drop reset_n asynchronously while in state TWO → out_valid=0 and in_ready=1 before the next edge.
